// File: rtl/audio_sample_sequencer.sv
// Per-sample scheduler: ADC pop -> noise -> FIR (+latency) -> DAC push, with write timeout.
// Define SEQ_DROP_STATS_EN to build the saturating drop counter; otherwise drop_cnt is tied to 0.
module audio_sample_sequencer #(
    parameter int unsigned FIR_LAT    = 2,
    parameter int unsigned WR_TIMEOUT = 1024,
    parameter int unsigned DROP_W     = 8
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic              noise_on,
    input  logic              filter_on,
    output logic              read,
    output logic              capture,
    output logic              noise_ena,
    output logic              filter_ena,
    output logic              write,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [3:0]  LAT_INIT = 4'(FIR_LAT);
    localparam logic [15:0] TO_LAST  = 16'(WR_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StRd, StNz, StFl, StFw, StWw, StWr} state_e;

    state_e      r_state, w_state_next;
    logic        r_mode_filter, w_mode_filter_next;
    logic [3:0]  r_lat_cnt, w_lat_cnt_next;
    logic [15:0] r_to_cnt, w_to_cnt_next;
    logic        r_read, r_capture, r_noise_ena, r_filter_ena, r_write, r_busy;

    // The noise choice is consumed in RD itself; only the filter choice is needed later.
    always_comb begin
        w_state_next       = r_state;
        w_mode_filter_next = r_mode_filter;
        w_lat_cnt_next     = r_lat_cnt;
        w_to_cnt_next      = '0;
        unique case (r_state)
            StIdle: if (read_ready) w_state_next = StRd;
            StRd: begin
                w_mode_filter_next = filter_on;
                if (noise_on)       w_state_next = StNz;
                else if (filter_on) w_state_next = StFl;
                else                w_state_next = StWw;
            end
            StNz: w_state_next = r_mode_filter ? StFl : StWw;
            StFl: begin
                w_lat_cnt_next = LAT_INIT;
                w_state_next   = (LAT_INIT != 4'd0) ? StFw : StWw;
            end
            StFw: begin
                w_lat_cnt_next = r_lat_cnt - 4'd1;
                if (r_lat_cnt <= 4'd1) w_state_next = StWw;
            end
            StWw: begin
                if (write_ready)              w_state_next = StWr;
                else if (r_to_cnt == TO_LAST) w_state_next = StIdle;
                else                          w_to_cnt_next = r_to_cnt + 16'd1;
            end
            StWr:    w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_mode_filter <= 1'b0;
            r_lat_cnt     <= '0;
            r_to_cnt      <= '0;
            r_read        <= 1'b0;
            r_capture     <= 1'b0;
            r_noise_ena   <= 1'b0;
            r_filter_ena  <= 1'b0;
            r_write       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_mode_filter <= w_mode_filter_next;
            r_lat_cnt     <= w_lat_cnt_next;
            r_to_cnt      <= w_to_cnt_next;
            r_read        <= (w_state_next == StRd);
            r_capture     <= (w_state_next == StRd);
            r_noise_ena   <= (w_state_next == StNz);
            r_filter_ena  <= (w_state_next == StFl);
            r_write       <= (w_state_next == StWr);
            r_busy        <= (w_state_next != StIdle);
        end
    end

    assign read       = r_read;
    assign capture    = r_capture;
    assign noise_ena  = r_noise_ena;
    assign filter_ena = r_filter_ena;
    assign write      = r_write;
    assign busy       = r_busy;

`ifdef SEQ_DROP_STATS_EN
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_drop;

    // A write_ready arriving in the timeout cycle wins, so it is excluded here.
    assign w_drop = (r_state == StWw) && !write_ready && (r_to_cnt == TO_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Randomized bench for audio_sample_sequencer against a timeline-based reference model.
module tb_audio_sample_sequencer;

    localparam int FIR_LAT    = 2;
    localparam int WR_TIMEOUT = 8;
    localparam int DROP_W     = 8;
    localparam int DROP_MAX   = (1 << DROP_W) - 1;
    localparam int NEVER      = 32'h7fff_ffff;

    logic              CLOCK_50 = 1'b0;
    logic              resetn = 1'b1;
    logic              read_ready = 1'b0, write_ready = 1'b0, noise_on = 1'b0, filter_on = 1'b0;
    logic              read, capture, noise_ena, filter_ena, write, busy;
    logic [DROP_W-1:0] drop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Model: absolute cycle numbers of the current sample's events.
    int k, t_read, t_write, ww_start, m_free_at, m_n, m_f, m_drops;
    bit m_wait;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_sample_sequencer #(
        .FIR_LAT   (FIR_LAT),
        .WR_TIMEOUT(WR_TIMEOUT),
        .DROP_W    (DROP_W)
    ) u_dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .read_ready (read_ready),
        .write_ready(write_ready),
        .noise_on   (noise_on),
        .filter_on  (filter_on),
        .read       (read),
        .capture    (capture),
        .noise_ena  (noise_ena),
        .filter_ena (filter_ena),
        .write      (write),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k         = 0;
        t_read    = -100;
        t_write   = -100;
        ww_start  = 0;
        m_free_at = 0;
        m_n       = 0;
        m_f       = 0;
        m_drops   = 0;
        m_wait    = 1'b0;
    endtask

    // Advance to cycle k using the inputs held during cycle k-1.
    task automatic model_step();
        k++;
        if (k - 1 >= m_free_at && read_ready) begin
            t_read    = k;
            m_free_at = NEVER;
        end
        if (k == t_read + 1) begin
            m_n      = noise_on ? 1 : 0;
            m_f      = filter_on ? 1 : 0;
            ww_start = t_read + 1 + m_n + (m_f != 0 ? 1 + FIR_LAT : 0);
            m_wait   = 1'b1;
        end
        if (m_wait && k - 1 >= ww_start) begin
            if (write_ready) begin
                t_write   = k;
                m_free_at = k + 1;
                m_wait    = 1'b0;
            end else if (k - 1 - ww_start == WR_TIMEOUT - 1) begin
                m_free_at = k;
                m_wait    = 1'b0;
                if (m_drops < DROP_MAX) m_drops++;
            end
        end
    endtask

    function automatic int exp_drop();
`ifdef SEQ_DROP_STATS_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int rr, input int wr, input int nz, input int fl);
        logic [5:0] e;
        @(posedge CLOCK_50);
        model_step();
        #1;
        e[5] = (k == t_read);
        e[4] = (k == t_read);
        e[3] = (m_n != 0) && (k == t_read + 1);
        e[2] = (m_f != 0) && (k == t_read + 1 + m_n);
        e[1] = (k == t_write);
        e[0] = (k < m_free_at);
        check("strobes", {26'd0, read, capture, noise_ena, filter_ena, write, busy}, {26'd0, e});
        check("drop_cnt", 32'(drop_cnt), exp_drop());
        read_ready  = int'($urandom_range(99)) < rr;
        write_ready = int'($urandom_range(99)) < wr;
        noise_on    = int'($urandom_range(99)) < nz;
        filter_on   = int'($urandom_range(99)) < fl;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        check("reset_outs", {18'd0, read, capture, noise_ena, filter_ena, write, busy, drop_cnt},
              32'd0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();

        // Bypass pulse, then both noise and filter.
        read_ready = 1'b1; write_ready = 1'b1;
        repeat (6) tick(0, 100, 0, 0);
        read_ready = 1'b1; noise_on = 1'b1; filter_on = 1'b1;
        repeat (10) tick(0, 100, 100, 100);

        // Back-to-back bypass samples.
        repeat (40) tick(100, 100, 0, 0);

        // Random traffic with switches toggling mid-sample.
        repeat (2000) tick(40, 70, 50, 50);
        repeat (1500) tick(60, 20, 50, 50);

        // Stalled DAC: many timeouts to saturate the drop counter.
        repeat (4500) tick(100, 0, 50, 50);
        check("drop_sat", 32'(drop_cnt), exp_drop());

        // Reset while waiting out FIR latency.
        repeat (20) tick(0, 100, 0, 0);
        read_ready = 1'b1; noise_on = 1'b0; filter_on = 1'b1; write_ready = 1'b1;
        repeat (3) tick(0, 100, 0, 100);
        apply_reset();
        repeat (30) tick(50, 80, 50, 50);

        // Resets at random points.
        repeat (25) begin
            repeat ($urandom_range(1, 15)) tick(50, 60, 50, 50);
            apply_reset();
        end
        repeat (300) tick(50, 60, 50, 50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
